// File: rtl/tor_network_emulator.sv
// ToR switch model: per-input skid register, per-output round-robin into a FIFO, fixed-latency
// egress delay line and saturating drop counters. Optional per-port stats: TOR_EMU_PORT_STATS_EN.
module tor_network_emulator #(
  parameter int NUM_PORTS  = 2,
  parameter int PKT_W      = 512,
  parameter int DEST_LSB   = 0,
  parameter int DEST_W     = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 mode,
  input  logic [NUM_PORTS*PKT_W-1:0] network_tx_in,
  input  logic [NUM_PORTS-1:0]       network_tx_valid_in,
  output logic [NUM_PORTS*PKT_W-1:0] network_rx_out,
  output logic [NUM_PORTS-1:0]       network_rx_valid_out,
  output logic [CNT_W-1:0]           drop_full_cnt,
`ifdef TOR_EMU_PORT_STATS_EN
  output logic [NUM_PORTS*CNT_W-1:0] tx_pkt_cnt,
  output logic [NUM_PORTS*CNT_W-1:0] rx_pkt_cnt,
`endif
  output logic [CNT_W-1:0]           drop_unroutable_cnt
);
  // Strobe-only links: a valid bit means a packet is present in that cycle; there is no ready,
  // so whatever cannot be held is dropped and counted instead of stalling the sender.
  localparam int IW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NS = LATENCY - 1;
  localparam int NW = IW + 1;
  localparam logic [DEST_W:0] NP_D = (DEST_W+1)'(NUM_PORTS);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] MODE_ROUTE = 2'd1;
  localparam logic [1:0] MODE_SELF = 2'd2;

  typedef logic [PKT_W-1:0] pkt_t;

  logic [NUM_PORTS-1:0] skid_vld_q, skid_vld_d, load, in_ok, gnt_vec, gnt_any, full, pop;
  logic [IW-1:0]        skid_dest_q [NUM_PORTS];
  pkt_t                 skid_pkt_q  [NUM_PORTS];
  logic [IW-1:0]        in_dest     [NUM_PORTS];
  logic [IW-1:0]        gnt_idx     [NUM_PORTS];
  logic [IW-1:0]        rr_q        [NUM_PORTS];
  pkt_t                 mem_q       [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]        wp_q        [NUM_PORTS];
  logic [AW-1:0]        rp_q        [NUM_PORTS];
  logic [AW:0]          cnt_q       [NUM_PORTS];
  logic [AW:0]          cnt_d       [NUM_PORTS];
  logic                 dl_vld_q    [NUM_PORTS][NS];
  pkt_t                 dl_pkt_q    [NUM_PORTS][NS];
  logic [NW-1:0]        n_full, n_unr;
  logic [CNT_W-1:0]     drop_full_q, drop_unr_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [NW-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin : p_dest
    logic [DEST_W-1:0] fld;
    for (int i = 0; i < NUM_PORTS; i++) begin
      fld        = network_tx_in[i*PKT_W + DEST_LSB +: DEST_W];
      in_ok[i]   = 1'b1;
      in_dest[i] = IW'((i + 1) % NUM_PORTS);
      case (mode)
        MODE_ROUTE: begin
          in_ok[i]   = ({1'b0, fld} < NP_D);
          in_dest[i] = fld[IW-1:0];
        end
        MODE_SELF: in_dest[i] = IW'(i);
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      full[j] = (cnt_q[j] == CNT_FULL);
      pop[j]  = (cnt_q[j] != '0);
    end
  end

  // Search starts at the round-robin pointer; a full queue withholds every grant.
  always_comb begin : p_arb
    int idx;
    gnt_vec = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      gnt_any[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
        idx = (int'(rr_q[j]) + off) % NUM_PORTS;
        if (!gnt_any[j] && !full[j] && skid_vld_q[idx] && (skid_dest_q[idx] == IW'(j))) begin
          gnt_any[j]   = 1'b1;
          gnt_idx[j]   = IW'(idx);
          gnt_vec[idx] = 1'b1;
        end
      end
      cnt_d[j] = cnt_q[j] + (AW+1)'(gnt_any[j]) - (AW+1)'(pop[j]);
    end
  end

  always_comb begin
    n_full = '0;
    n_unr  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      load[i]       = network_tx_valid_in[i] && in_ok[i] && (!skid_vld_q[i] || gnt_vec[i]);
      n_full        = n_full + NW'(network_tx_valid_in[i] && in_ok[i] && skid_vld_q[i] && !gnt_vec[i]);
      n_unr         = n_unr + NW'(network_tx_valid_in[i] && !in_ok[i]);
      skid_vld_d[i] = load[i] || (skid_vld_q[i] && !gnt_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_vld_q  <= '0;
      drop_full_q <= '0;
      drop_unr_q  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        skid_dest_q[i] <= '0;
        skid_pkt_q[i]  <= '0;
        rr_q[i]        <= '0;
        wp_q[i]        <= '0;
        rp_q[i]        <= '0;
        cnt_q[i]       <= '0;
        for (int s = 0; s < NS; s++) begin
          dl_vld_q[i][s] <= 1'b0;
          dl_pkt_q[i][s] <= '0;
        end
      end
    end else begin
      skid_vld_q  <= skid_vld_d;
      drop_full_q <= sat_add(drop_full_q, n_full);
      drop_unr_q  <= sat_add(drop_unr_q, n_unr);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (load[i]) begin
          skid_pkt_q[i]  <= network_tx_in[i*PKT_W +: PKT_W];
          skid_dest_q[i] <= in_dest[i];
        end
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (gnt_any[j]) begin
          wp_q[j] <= wp_q[j] + 1'b1;
          rr_q[j] <= (gnt_idx[j] == IW'(NUM_PORTS - 1)) ? '0 : gnt_idx[j] + 1'b1;
        end
        if (pop[j]) rp_q[j] <= rp_q[j] + 1'b1;
        cnt_q[j] <= cnt_d[j];
        // Data stages only load on valid so the output holds its last packet.
        dl_vld_q[j][0] <= pop[j];
        if (pop[j]) dl_pkt_q[j][0] <= mem_q[j][rp_q[j]];
        for (int s = 1; s < NS; s++) begin
          dl_vld_q[j][s] <= dl_vld_q[j][s-1];
          if (dl_vld_q[j][s-1]) dl_pkt_q[j][s] <= dl_pkt_q[j][s-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (gnt_any[j]) mem_q[j][wp_q[j]] <= skid_pkt_q[gnt_idx[j]];
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    assign network_rx_out[j*PKT_W +: PKT_W] = dl_pkt_q[j][NS-1];
    assign network_rx_valid_out[j]          = dl_vld_q[j][NS-1];
  end
  assign drop_full_cnt       = drop_full_q;
  assign drop_unroutable_cnt = drop_unr_q;

`ifdef TOR_EMU_PORT_STATS_EN
  logic [CNT_W-1:0] tx_cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] rx_cnt_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!reset_n) begin
        tx_cnt_q[i] <= '0;
        rx_cnt_q[i] <= '0;
      end else begin
        tx_cnt_q[i] <= sat_add(tx_cnt_q[i], NW'(load[i]));
        rx_cnt_q[i] <= sat_add(rx_cnt_q[i], NW'(network_rx_valid_out[i]));
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
    assign tx_pkt_cnt[i*CNT_W +: CNT_W] = tx_cnt_q[i];
    assign rx_pkt_cnt[i*CNT_W +: CNT_W] = rx_cnt_q[i];
  end
`endif
endmodule
